uart_tx: RTL

Serial transmitter for the I/O path. It accepts bytes from the I/O memory bridge on `data_in`, buffers them in a small FIFO, and shifts each one out on `tx` as an 8N1 UART frame. The frame is 1 start bit, 8 data bits sent LSB first, and 1 stop bit. The block sits directly downstream of the I/O device and is the only driver of the off-chip TX line.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_if.sv | 15 +
 rtl/uart_tx_fifo.sv | 50 +++++
 rtl/uart_tx.sv | 123 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions, used by uart_tx and the planned uart_rx.
//   uart_tx_state_t   : transmitter FSM states
//   UART_DATA_BITS    : payload bits per frame
//   UART_FRAME_BITS   : start + data + stop
//   UART_CLKS_PER_BIT : default oversampling (clocks per serial bit)
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_FRAME_BITS   = 10;
  localparam int UART_CLKS_PER_BIT = 16;
endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the I/O memory bridge and the UART transmitter.
//   data_in  : byte to send
//   tx_start : data_in valid this cycle
//   tx_ready : transmitter can take a byte this cycle
// master = byte producer, slave = uart_tx.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data_in;
  logic                      tx_start;
  logic                      tx_ready;

  modport master (output data_in, tx_start, input tx_ready);
  modport slave  (input data_in, tx_start, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO, power-of-2 depth.
//   clk, rst     : clock, synchronous active-high reset
//   push / wdata : write request and data (ignored when full)
//   pop  / rdata : read request (ignored when empty); rdata is the head, combinational
//   count        : occupancy, 0..DEPTH
//   full, empty  : occupancy flags
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO refuses a push even if a pop frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with input byte FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : byte handshake (data_in / tx_start / tx_ready)
//   tx         : serial line, idles high, registered
//   tx_busy    : frame in progress
//   tx_done    : one-cycle pulse on the last cycle of each stop bit
//   fifo_count : bytes waiting in the FIFO
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_if.slave                    bus,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int            BW          = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  uart_tx_state_t            state_q;
  logic [BW-1:0]             baud_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      tx_q, done_q;

  logic [UART_DATA_BITS-1:0] head;
  logic                      fifo_full, fifo_empty, pop, baud_zero;

  assign baud_zero = (baud_q == '0);
  // Pop from IDLE, or at the end of a stop bit so the next start bit follows with no gap.
  assign pop = !fifo_empty && (state_q == IDLE || (state_q == STOP && baud_zero));

  assign bus.tx_ready = !fifo_full;

  uart_tx_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.tx_start),
    .pop   (pop),
    .wdata (bus.data_in),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      // Set one cycle early so the registered pulse lands on the final stop cycle.
      done_q <= (state_q == STOP) && (baud_q == BW'(1));
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q   <= head;
            bit_idx_q <= '0;
            baud_q    <= BAUD_RELOAD;
            tx_q      <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (baud_zero) begin
            baud_q  <= BAUD_RELOAD;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        DATA: begin
          if (baud_zero) begin
            baud_q <= BAUD_RELOAD;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              tx_q      <= 1'b1;
              state_q   <= STOP;
            end else begin
              // Line takes the next bit, which is shift_q[1] before the shift lands.
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        STOP: begin
          if (baud_zero) begin
            if (pop) begin
              shift_q   <= head;
              bit_idx_q <= '0;
              baud_q    <= BAUD_RELOAD;
              tx_q      <= 1'b0;
              state_q   <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign tx_busy = (state_q != IDLE);
endmodule
